// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the HI/LO multiply/divide unit (divide ops live only with MULDIV_DIV_EN)
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Counter value of the final radix-2 step.
  localparam int LAST_ITER = 31;

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate (absolute value when neg is the sign bit)
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  // Negate when asked; 0x80..0 maps to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    y = neg ? (~a + 1'b1) : a;
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS HI/LO multiply/divide unit; divide datapath compiled in only with MULDIV_DIV_EN
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  // Multiply: {partial product, remaining multiplier bits}. Divide: {partial remainder, quotient/dividend bits}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [WIDTH:0]     mul_sum;
  logic               neg_res;
  logic               op_signed;
  logic               op_ok;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_rs (
    .a   (rs_data),
    .neg (op_signed & rs_data[WIDTH-1]),
    .y   (rs_abs)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_rt (
    .a   (rt_data),
    .neg (op_signed & rt_data[WIDTH-1]),
    .y   (rt_abs)
  );

  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .a   (acc),
    .neg (neg_res),
    .y   (prod_fix)
  );

`ifdef MULDIV_DIV_EN
  logic             is_div;
  logic             neg_rem;
  logic             div_by_zero;
  logic [WIDTH-1:0] raw_rs;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  assign op_ok = 1'b1;

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
    .a   (acc[WIDTH-1:0]),
    .neg (neg_res),
    .y   (quo_fix)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .neg (neg_rem),
    .y   (rem_fix)
  );
`else
  // Without the divide datapath, DIV/DIVU requests are simply not accepted.
  assign op_ok = ~op[1];
`endif

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[WIDTH]) begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  // Control FSM plus HI/LO ownership: accept in IDLE, iterate in RUN, sign-correct and write in FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div      <= 1'b0;
      neg_rem     <= 1'b0;
      div_by_zero <= 1'b0;
      raw_rs      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && op_ok) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, rs_abs};
            opnd    <= rt_abs;
            neg_res <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            is_div      <= op[1];
            neg_rem     <= op_signed & rs_data[WIDTH-1];
            div_by_zero <= (rt_data == '0);
            raw_rs      <= rs_data;
`endif
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(LAST_ITER)) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= '0;
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            if (div_by_zero) begin
              hi <= raw_rs;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
`else
          {hi, lo} <= prod_fix;
`endif
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (divide expectations follow MULDIV_DIV_EN)
module tb_muldiv_unit;
  import muldiv_pkg::*;

  // Edges from the accepting edge to the first sample showing done (done lands in cycle k+34).
  localparam int LAT = 33;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit op_supported(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return ~o[1];
`endif
  endfunction

  // Reference: {hi,lo} from plain integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          ia;
    int          ib;
    longint      p;
    logic [63:0] u;
    ia = a;
    ib = b;
    case (o)
      2'd0: begin
        p = longint'(ia) * longint'(ib);
        return p;
      end
      2'd1: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int max, output int n, output bit busy_ok,
                           output logic [31:0] pre_hi, output logic [31:0] pre_lo);
    n       = 0;
    busy_ok = 1'b1;
    pre_hi  = hi;
    pre_lo  = lo;
    while (n < max) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      pre_hi = hi;
      pre_lo = lo;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    int          n;
    int          n_done;
    bit          bok;
    logic [31:0] ph;
    logic [31:0] pl;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (op_supported(o)) begin
      chk({name, " busy_after_accept"}, 64'(busy), 64'd1);
      wait_done(60, n, bok, ph, pl);
      chk({name, " latency"}, 64'(n), 64'(LAT));
      chk({name, " busy_during_run"}, 64'(bok), 64'd1);
      chk({name, " hilo_held_until_done"}, {ph, pl}, {m_hi, m_lo});
      chk({name, " busy_at_done"}, 64'(busy), 64'd0);
      chk({name, " result_hi_lo"}, {hi, lo}, {eh, el});
      m_hi = eh;
      m_lo = el;
    end else begin
      chk({name, " ignored_busy"}, 64'(busy), 64'd0);
      n_done = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done) n_done++;
      end
      chk({name, " ignored_no_done"}, 64'(n_done), 64'd0);
      chk({name, " ignored_hilo"}, {hi, lo}, {m_hi, m_lo});
    end
  endtask

  initial begin
    vec_t        vecs[10];
    int          n;
    int          n_done;
    bit          bok;
    logic [31:0] ph;
    logic [31:0] pl;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
    vecs[3] = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by_zero"};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow"};
    vecs[5] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin"};
    vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2"};
    vecs[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by_zero"};
    vecs[8] = '{OP_MULTU, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         "multu_zero"};
    vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, "divu_by_one"};

    start   = 1'b0;
    op      = 2'd0;
    rs_data = '0;
    rt_data = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wdata   = '0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi_lo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    m_hi  = '0;
    m_lo  = '0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].name);
    end

    // Requests arriving mid-run are ignored; done lasts one cycle.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs_data = 32'd5; rt_data = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd3;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAA;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("midrun hilo_untouched", {hi, lo}, {m_hi, m_lo});
    chk("midrun busy", 64'(busy), 64'd1);
    wait_done(60, n, bok, ph, pl);
    chk("midrun latency", 64'(n), 64'(LAT - 10));
    chk("midrun result", {hi, lo}, {32'd0, 32'd30});
    m_hi = 32'd0;
    m_lo = 32'd30;
    @(posedge clk);
    #1;
    chk("done single_cycle", 64'(done), 64'd0);

    // MTLO alone, then MTHI+MTLO together, in IDLE.
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    chk("mtlo idle", {hi, lo}, {m_hi, 32'h1234});
    m_lo = 32'h1234;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo together", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    m_hi = 32'hCAFE_F00D;
    m_lo = 32'hCAFE_F00D;

    // start and mtlo in the same IDLE cycle: start wins.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd3;
    mtlo = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0; mtlo = 1'b0;
    chk("start_wins lo_not_written", 64'(lo), 64'(m_lo));
    wait_done(60, n, bok, ph, pl);
    chk("start_wins latency", 64'(n), 64'(LAT - 1) + 64'd1);
    chk("start_wins result", {hi, lo}, {32'd0, 32'd6});
    m_hi = 32'd0;
    m_lo = 32'd6;

    // Reset during a MULT aborts it with no done.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_data = 32'hFFFF_FFFD; rt_data = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi_lo", {hi, lo}, 64'd0);
    chk("abort done", 64'(done), 64'd0);
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort no_done", 64'(n_done), 64'd0);
    m_hi = '0;
    m_lo = '0;

    // Randomized operations against the arithmetic reference, issued back to back.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] r;
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      r = ref_res(o, a, b);
      run_op(o, a, b, r[63:32], r[31:0], $sformatf("rand%0d_op%0d_%h_%h", i, o, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
